cv32e40x_id_operand_stage: RTL and testbench
============================================

Name: cv32e40x_id_operand_stage

Overview:
- Consumes the bypass-control bundle produced by the hazard/bypass controller.
- Selects forwarded operands for the ID stage and combines the hazard stall flags into the ID handshake.
- Holds the operand portion of the ID/EX pipeline register with a valid/ready handshake, and keeps a saturating hazard-stall cycle counter for performance monitoring.
- Sits between register-file read/forward sources and the EX stage.

Parameters:
DATA_WIDTH, 32, operand and forward data width
CNT_WIDTH, 32, hazard-stall counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
id_valid_i  input  1  valid instruction in ID (IF/ID register)
ex_ready_i  input  1  EX stage can accept a new instruction
halt_id_i  input  1  controller halt of ID
kill_id_i  input  1  controller kill of ID and of ID/EX register
operand_a_fw_sel_i  input  2  00 regfile, 01 EX forward, 10 WB forward, 11 treated as regfile
operand_b_fw_sel_i  input  2  same encoding as operand_a_fw_sel_i
jalr_fw_sel_i  input  1  0 regfile rs1, 1 WB forward
jalr_en_i  input  1  JALR decoded in ID
load_stall_i  input  1  load/XIF use hazard
jalr_stall_i  input  1  jump-register hazard
csr_stall_i  input  1  CSR read-after-write hazard
wfi_stall_i  input  1  WFI in EX
mnxti_stall_i  input  1  mnxti read in EX
rf_rdata_a_i  input  DATA_WIDTH  regfile port 0 data
rf_rdata_b_i  input  DATA_WIDTH  regfile port 1 data
ex_fw_data_i  input  DATA_WIDTH  EX result for forwarding
wb_fw_data_i  input  DATA_WIDTH  WB result for forwarding
cnt_clr_i  input  1  clear hazard-stall counter
id_ready_o  output  1  ID may hand over (IF/ID may advance)
hazard_stall_o  output  1  combined hazard stall
jalr_base_o  output  DATA_WIDTH  combinational jump base
ex_valid_o  output  1  ID/EX register valid
operand_a_o  output  DATA_WIDTH  registered operand A
operand_b_o  output  DATA_WIDTH  registered operand B
stall_cnt_o  output  CNT_WIDTH  hazard-stall cycle count

Behaviour:
- Reset values: ex_valid_o=0, operand_a_o=0, operand_b_o=0, stall_cnt_o=0. Reset overrides every other input in the same cycle.
- hazard_stall_o (combinational) = load_stall_i | (jalr_stall_i & jalr_en_i) | csr_stall_i | wfi_stall_i | mnxti_stall_i.
- Operand muxes (combinational):
  - 00 or 11 selects rf_rdata.
  - 01 selects ex_fw_data_i.
  - 10 selects wb_fw_data_i.
- jalr_base_o = jalr_fw_sel_i ? wb_fw_data_i : rf_rdata_a_i. This output is unregistered, with no latency.
- id_ready_o:
  - Equals 1 when kill_id_i=1, so the killed instruction drains.
  - Otherwise equals ex_ready_i & ~halt_id_i & ~hazard_stall_o.
- Transfer condition: id_valid_i & id_ready_o & ~kill_id_i.
- ID/EX register update, priority order:
  1. rst.
  2. kill_id_i: ex_valid_o<=0. Operands hold.
  3. Transfer: ex_valid_o<=1, and both operands load the mux outputs.
  4. ex_ready_i: ex_valid_o<=0, inserting a bubble. This covers stall, halt and empty ID.
  5. Otherwise: hold all state, because EX is back-pressuring.
- Operand registers change only on transfer, never on a bubble. This is clock-enabled data.
- Back-to-back: a transfer every cycle while ex_ready_i=1 and no stall, giving a throughput of 1 instruction/cycle.
- Stall counter:
  - Increments when id_valid_i & hazard_stall_o & ~halt_id_i & ~kill_id_i & ex_ready_i. Back-pressure cycles are not counted as hazard cycles.
  - cnt_clr_i has priority over increment and sets the counter to 0.
  - Saturates at all-ones; no wrap.
- Simultaneous halt and hazard stall: halt takes precedence, and the counter does not increment.
- Reset mid-stall: ex_valid_o=0 and stall_cnt_o=0 on the next edge. Held operands clear to 0.
- No X-propagation: selector 11 is defined as regfile.

Test Plan:
- Pass-through transfer: id_valid=1, ex_ready=1, sel_a=00, sel_b=01, rf_a=0x11, ex_fw=0x22 -> next cycle ex_valid=1, op_a=0x11, op_b=0x22.
- WB forward and JALR base:
  - Inputs: sel_a=10, wb_fw=0xCAFE0000, jalr_fw_sel=1.
  - Response: jalr_base_o=0xCAFE0000 in the same cycle, and op_a=0xCAFE0000 after the edge.
- Load-use stall:
  - Inputs: load_stall=1 for 2 cycles with id_valid=1, ex_ready=1.
  - Response: id_ready=0 and ex_valid=0 (bubbles) for 2 cycles, with operands held; stall_cnt=2; transfer on the 3rd cycle.
- JALR stall qualification:
  - jalr_stall=1, jalr_en=0 -> no stall, transfer.
  - jalr_en=1 -> stall, counter +1.
- Back-pressure and kill:
  - ex_ready=0 with ex_valid=1 -> ex_valid and operands hold, counter unchanged.
  - Then kill_id=1 -> id_ready=1, ex_valid=0 next cycle.
- Counter saturation and clear:
  - Preload via CNT_WIDTH=4 build: 15 stall cycles -> stall_cnt=0xF, and it stays at 0xF after a 16th.
  - cnt_clr together with a stall -> 0.
  - rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/cv32e40x_id_operand_stage.sv
// ID operand stage: forward-select muxes, hazard/handshake combine,
// ID/EX operand register and saturating hazard-stall counter.
module cv32e40x_id_operand_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic                  ex_ready_i,
  input  logic                  halt_id_i,
  input  logic                  kill_id_i,
  input  logic [1:0]            operand_a_fw_sel_i,
  input  logic [1:0]            operand_b_fw_sel_i,
  input  logic                  jalr_fw_sel_i,
  input  logic                  jalr_en_i,
  input  logic                  load_stall_i,
  input  logic                  jalr_stall_i,
  input  logic                  csr_stall_i,
  input  logic                  wfi_stall_i,
  input  logic                  mnxti_stall_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata_b_i,
  input  logic [DATA_WIDTH-1:0] ex_fw_data_i,
  input  logic [DATA_WIDTH-1:0] wb_fw_data_i,
  input  logic                  cnt_clr_i,
  output logic                  id_ready_o,
  output logic                  hazard_stall_o,
  output logic [DATA_WIDTH-1:0] jalr_base_o,
  output logic                  ex_valid_o,
  output logic [DATA_WIDTH-1:0] operand_a_o,
  output logic [DATA_WIDTH-1:0] operand_b_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  logic [DATA_WIDTH-1:0] op_a_mux;
  logic [DATA_WIDTH-1:0] op_b_mux;
  logic                  transfer;
  logic                  cnt_inc;
  logic                  cnt_sat;

  assign hazard_stall_o = load_stall_i
                        | (jalr_stall_i & jalr_en_i)
                        | csr_stall_i
                        | wfi_stall_i
                        | mnxti_stall_i;

  // Selector 11 falls back to the regfile so no X leaks into EX
  always_comb begin
    op_a_mux = rf_rdata_a_i;
    unique case (operand_a_fw_sel_i)
      2'b01:   op_a_mux = ex_fw_data_i;
      2'b10:   op_a_mux = wb_fw_data_i;
      default: op_a_mux = rf_rdata_a_i;
    endcase
  end

  always_comb begin
    op_b_mux = rf_rdata_b_i;
    unique case (operand_b_fw_sel_i)
      2'b01:   op_b_mux = ex_fw_data_i;
      2'b10:   op_b_mux = wb_fw_data_i;
      default: op_b_mux = rf_rdata_b_i;
    endcase
  end

  assign jalr_base_o = jalr_fw_sel_i ? wb_fw_data_i
                                     : rf_rdata_a_i;

  // A killed instruction must drain regardless of stalls
  assign id_ready_o = kill_id_i
                    | (ex_ready_i & ~halt_id_i & ~hazard_stall_o);

  assign transfer = id_valid_i & id_ready_o & ~kill_id_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_o  <= 1'b0;
      operand_a_o <= '0;
      operand_b_o <= '0;
    end else if (kill_id_i) begin
      ex_valid_o  <= 1'b0;
    end else if (transfer) begin
      ex_valid_o  <= 1'b1;
      operand_a_o <= op_a_mux;
      operand_b_o <= op_b_mux;
    end else if (ex_ready_i) begin
      ex_valid_o  <= 1'b0;
    end
  end

  // Back-pressure and halt cycles are not hazard cycles
  assign cnt_inc = id_valid_i & hazard_stall_o & ~halt_id_i
                 & ~kill_id_i & ex_ready_i;
  assign cnt_sat = &stall_cnt_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      stall_cnt_o <= '0;
    end else if (cnt_inc && !cnt_sat) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40x_id_operand_stage.sv
// Directed bench for cv32e40x_id_operand_stage
// (4-bit counter build to reach saturation quickly).
module tb_cv32e40x_id_operand_stage;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, ex_ready, halt_id, kill_id;
  logic [1:0]    sel_a, sel_b;
  logic          jalr_fw_sel, jalr_en;
  logic          load_stall, jalr_stall, csr_stall;
  logic          wfi_stall, mnxti_stall;
  logic [DW-1:0] rf_a, rf_b, ex_fw, wb_fw;
  logic          cnt_clr;
  logic          id_ready, hazard;
  logic [DW-1:0] jalr_base, op_a, op_b;
  logic          ex_valid;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40x_id_operand_stage #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid_i        (id_valid),
    .ex_ready_i        (ex_ready),
    .halt_id_i         (halt_id),
    .kill_id_i         (kill_id),
    .operand_a_fw_sel_i(sel_a),
    .operand_b_fw_sel_i(sel_b),
    .jalr_fw_sel_i     (jalr_fw_sel),
    .jalr_en_i         (jalr_en),
    .load_stall_i      (load_stall),
    .jalr_stall_i      (jalr_stall),
    .csr_stall_i       (csr_stall),
    .wfi_stall_i       (wfi_stall),
    .mnxti_stall_i     (mnxti_stall),
    .rf_rdata_a_i      (rf_a),
    .rf_rdata_b_i      (rf_b),
    .ex_fw_data_i      (ex_fw),
    .wb_fw_data_i      (wb_fw),
    .cnt_clr_i         (cnt_clr),
    .id_ready_o        (id_ready),
    .hazard_stall_o    (hazard),
    .jalr_base_o       (jalr_base),
    .ex_valid_o        (ex_valid),
    .operand_a_o       (op_a),
    .operand_b_o       (op_b),
    .stall_cnt_o       (stall_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 0; ex_ready = 0; halt_id = 0; kill_id = 0;
    sel_a = 2'b00; sel_b = 2'b00;
    jalr_fw_sel = 0; jalr_en = 0;
    load_stall = 0; jalr_stall = 0; csr_stall = 0;
    wfi_stall = 0; mnxti_stall = 0;
    rf_a = '0; rf_b = '0; ex_fw = '0; wb_fw = '0;
    cnt_clr = 0;
    step();
    step();
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;

    // pass-through transfer
    id_valid = 1; ex_ready = 1;
    sel_a = 2'b00; sel_b = 2'b01;
    rf_a = 32'h11; ex_fw = 32'h22;
    #1;
    chk("pt_id_ready", 32'(id_ready), 32'd1);
    chk("pt_hazard", 32'(hazard), 32'd0);
    step();
    chk("pt_valid", 32'(ex_valid), 32'd1);
    chk("pt_op_a", op_a, 32'h11);
    chk("pt_op_b", op_b, 32'h22);

    // WB forward, jalr base, selector 11 = regfile
    sel_a = 2'b10; sel_b = 2'b11;
    wb_fw = 32'hCAFE0000; rf_b = 32'h33;
    jalr_fw_sel = 1;
    #1;
    chk("jalr_wb", jalr_base, 32'hCAFE0000);
    jalr_fw_sel = 0;
    #1;
    chk("jalr_rf", jalr_base, 32'h11);
    step();
    chk("wb_op_a", op_a, 32'hCAFE0000);
    chk("sel11_op_b", op_b, 32'h33);

    // load-use stall for two cycles
    sel_a = 2'b00; rf_a = 32'h44; load_stall = 1;
    #1;
    chk("ld_id_ready", 32'(id_ready), 32'd0);
    chk("ld_hazard", 32'(hazard), 32'd1);
    step();
    chk("ld1_valid", 32'(ex_valid), 32'd0);
    chk("ld1_op_a", op_a, 32'hCAFE0000);
    chk("ld1_cnt", 32'(stall_cnt), 32'd1);
    step();
    chk("ld2_valid", 32'(ex_valid), 32'd0);
    chk("ld2_cnt", 32'(stall_cnt), 32'd2);
    load_stall = 0;
    step();
    chk("ld3_valid", 32'(ex_valid), 32'd1);
    chk("ld3_op_a", op_a, 32'h44);
    chk("ld3_cnt", 32'(stall_cnt), 32'd2);

    // other stall sources each raise hazard
    csr_stall = 1; #1;
    chk("csr_hazard", 32'(hazard), 32'd1);
    csr_stall = 0; wfi_stall = 1; #1;
    chk("wfi_hazard", 32'(hazard), 32'd1);
    wfi_stall = 0; mnxti_stall = 1; #1;
    chk("mnxti_hazard", 32'(hazard), 32'd1);
    mnxti_stall = 0;

    // jalr stall qualified by jalr_en
    jalr_stall = 1; jalr_en = 0; rf_a = 32'h55;
    #1;
    chk("jq_hazard0", 32'(hazard), 32'd0);
    step();
    chk("jq_valid", 32'(ex_valid), 32'd1);
    chk("jq_op_a", op_a, 32'h55);
    chk("jq_cnt", 32'(stall_cnt), 32'd2);
    jalr_en = 1;
    #1;
    chk("jq_hazard1", 32'(hazard), 32'd1);
    step();
    chk("jq_stall_valid", 32'(ex_valid), 32'd0);
    chk("jq_stall_cnt", 32'(stall_cnt), 32'd3);
    jalr_stall = 0; jalr_en = 0;

    // back-pressure holds state and does not count
    rf_a = 32'h66;
    step();
    chk("bp_fill_valid", 32'(ex_valid), 32'd1);
    chk("bp_fill_op_a", op_a, 32'h66);
    ex_ready = 0; load_stall = 1; rf_a = 32'h77;
    #1;
    chk("bp_id_ready", 32'(id_ready), 32'd0);
    step();
    chk("bp_valid", 32'(ex_valid), 32'd1);
    chk("bp_op_a", op_a, 32'h66);
    chk("bp_cnt", 32'(stall_cnt), 32'd3);
    load_stall = 0;
    step();
    chk("bp2_valid", 32'(ex_valid), 32'd1);
    chk("bp2_op_a", op_a, 32'h66);

    // kill drains even under back-pressure
    kill_id = 1;
    #1;
    chk("kill_id_ready", 32'(id_ready), 32'd1);
    step();
    chk("kill_valid", 32'(ex_valid), 32'd0);
    chk("kill_op_a", op_a, 32'h66);
    kill_id = 0;

    // halt beats hazard: bubble, no count
    ex_ready = 1; halt_id = 1; load_stall = 1;
    #1;
    chk("halt_id_ready", 32'(id_ready), 32'd0);
    step();
    chk("halt_valid", 32'(ex_valid), 32'd0);
    chk("halt_cnt", 32'(stall_cnt), 32'd3);
    halt_id = 0;

    // clear, then saturate the 4-bit counter
    cnt_clr = 1;
    step();
    chk("clr_cnt", 32'(stall_cnt), 32'd0);
    cnt_clr = 0;
    for (int i = 0; i < 15; i++) step();
    chk("sat15_cnt", 32'(stall_cnt), 32'hF);
    step();
    chk("sat16_cnt", 32'(stall_cnt), 32'hF);
    cnt_clr = 1;
    step();
    chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
    cnt_clr = 0;
    step();
    step();
    chk("restall_cnt", 32'(stall_cnt), 32'd2);

    // reset mid-stall clears everything
    rst = 1;
    step();
    chk("rstm_valid", 32'(ex_valid), 32'd0);
    chk("rstm_op_a", op_a, 32'd0);
    chk("rstm_op_b", op_b, 32'd0);
    chk("rstm_cnt", 32'(stall_cnt), 32'd0);
    rst = 0; load_stall = 0; rf_a = 32'h88;
    step();
    chk("post_valid", 32'(ex_valid), 32'd1);
    chk("post_op_a", op_a, 32'h88);

    // reset overrides a pending transfer
    rst = 1; rf_a = 32'h99;
    step();
    chk("rsto_valid", 32'(ex_valid), 32'd0);
    chk("rsto_op_a", op_a, 32'd0);
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
